// File: rtl/conv_reg_pkg.sv
// Shared constants and helpers for the programmable-delay register line.
package conv_reg_pkg;

  localparam int unsigned MAX_LENGTH_LIMIT = 64;
  localparam int unsigned DEF_WIDTH        = 16;
  localparam int unsigned DEF_MAX_LENGTH   = 8;
  localparam int unsigned DEF_INIT_STATE   = 0;

  // Number of bits needed to hold values 0..v-1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/conv_reg_stage.sv
// One enabled, synchronously reset {valid, data} register stage.
module conv_reg_stage #(
  parameter int unsigned      WIDTH      = 16,
  parameter logic [WIDTH-1:0] INIT_STATE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  input  logic             v,
  output logic [WIDTH-1:0] q,
  output logic             qv
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q  <= INIT_STATE;
      qv <= 1'b0;
    end else if (en) begin
      q  <= d;
      qv <= v;
    end
  end

endmodule

// File: rtl/conv_reg_prog.sv
// Register delay line with run-time selectable tap and fill-qualified valid.
// Optional registered out-of-range flag on delay_err when CONV_REG_ERR_EN is defined.
module conv_reg_prog
  import conv_reg_pkg::*;
#(
  parameter int unsigned      WIDTH      = DEF_WIDTH,
  parameter int unsigned      MAX_LENGTH = DEF_MAX_LENGTH,
  parameter logic [WIDTH-1:0] INIT_STATE = WIDTH'(DEF_INIT_STATE),
  parameter int unsigned      DW         = clog2(MAX_LENGTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DW-1:0]    delay,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
`ifdef CONV_REG_ERR_EN
  output logic             delay_err,
`endif
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid
);

  localparam logic [DW-1:0] MAX_D = DW'(MAX_LENGTH);

  // Index 0 is the live input so a zero delay taps straight through.
  logic [WIDTH-1:0] chain_d [MAX_LENGTH+1];
  logic             chain_v [MAX_LENGTH+1];
  logic [DW-1:0]    d_eff;
  logic [DW-1:0]    d_q;
  logic [DW-1:0]    fill;

  assign chain_d[0] = in_data;
  assign chain_v[0] = in_valid;

  for (genvar i = 1; i <= int'(MAX_LENGTH); i++) begin : g_stage
    conv_reg_stage #(
      .WIDTH      (WIDTH),
      .INIT_STATE (INIT_STATE)
    ) u_stage (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .d   (chain_d[i-1]),
      .v   (chain_v[i-1]),
      .q   (chain_d[i]),
      .qv  (chain_v[i])
    );
  end

  assign d_eff = (delay > MAX_D) ? MAX_D : delay;

  // Reset captures the current delay so the first enabled edge is not seen as a change.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill <= '0;
      d_q  <= d_eff;
    end else begin
      if (d_eff != d_q) begin
        fill <= '0;
      end else if (en && (fill < MAX_D)) begin
        fill <= fill + DW'(1);
      end
      d_q <= d_eff;
    end
  end

  assign out_data  = chain_d[d_eff];
  assign out_valid = chain_v[d_eff] & (fill >= d_eff);

`ifdef CONV_REG_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      delay_err <= 1'b0;
    end else begin
      delay_err <= (delay > MAX_D);
    end
  end
`endif

endmodule

// File: tb/tb_conv_reg_prog.sv
// Directed plus randomized bench for conv_reg_prog against a queue-based reference model.
module tb_conv_reg_prog;

  localparam int unsigned W    = 16;
  localparam int unsigned ML   = 8;
  localparam int unsigned DW   = 4;
  localparam logic [W-1:0] INIT = 16'h5A5A;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [DW-1:0] delay;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic [W-1:0]  out_data;
  logic          out_valid;
`ifdef CONV_REG_ERR_EN
  logic          delay_err;
  logic          exp_err;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: newest sample at index 0, count of enabled edges since last D change.
  logic [W-1:0] qd [$];
  logic         qv [$];
  int           cnt    = 0;
  int           prev_d = 0;
  logic [W-1:0] exp_d;
  logic         exp_v;

  always #5 clk = ~clk;

  conv_reg_prog #(
    .WIDTH      (W),
    .MAX_LENGTH (ML),
    .INIT_STATE (INIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .delay     (delay),
    .in_data   (in_data),
    .in_valid  (in_valid),
`ifdef CONV_REG_ERR_EN
    .delay_err (delay_err),
`endif
    .out_data  (out_data),
    .out_valid (out_valid)
  );

  function automatic int clampd(input int d);
    return (d > int'(ML)) ? int'(ML) : d;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, advance the model on the edge, then compare just after it.
  task automatic step(input logic r, input logic e, input int dl,
                      input logic [W-1:0] d, input logic v);
    int dd;
    rst      = r;
    en       = e;
    delay    = DW'(dl);
    in_data  = d;
    in_valid = v;
    dd       = clampd(dl);
    @(posedge clk);
    if (r) begin
      qd.delete();
      qv.delete();
      for (int i = 0; i < int'(ML); i++) begin
        qd.push_back(INIT);
        qv.push_back(1'b0);
      end
      cnt = 0;
    end else begin
      if (dd != prev_d) cnt = 0;
      else if (e && cnt < int'(ML)) cnt++;
      if (e) begin
        qd.push_front(d);
        qv.push_front(v);
        qd = qd[0:ML-1];
        qv = qv[0:ML-1];
      end
    end
    prev_d = dd;
`ifdef CONV_REG_ERR_EN
    exp_err = r ? 1'b0 : (dl > int'(ML));
`endif
    #1;
    if (dd == 0) begin
      exp_d = d;
      exp_v = v;
    end else begin
      exp_d = qd[dd-1];
      exp_v = qv[dd-1] && (cnt >= dd);
    end
    check("out_data", 32'(out_data), 32'(exp_d));
    check("out_valid", 32'(out_valid), 32'(exp_v));
`ifdef CONV_REG_ERR_EN
    check("delay_err", 32'(delay_err), 32'(exp_err));
`endif
  endtask

  initial begin
    int dsel;
    rst = 1'b1; en = 1'b0; delay = '0; in_data = '0; in_valid = 1'b0;

    // Reset state
    step(1'b1, 1'b0, 3, 16'h0000, 1'b0);
    step(1'b1, 1'b0, 3, 16'h0000, 1'b0);
    check("rst_data", 32'(out_data), 32'(INIT));
    check("rst_valid", 32'(out_valid), 32'd0);

    // Delay 3 with a counting input
    for (int n = 1; n <= 12; n++) begin
      step(1'b0, 1'b1, 3, W'(n), 1'b1);
      if (n == 2) check("d3_not_yet_valid", 32'(out_valid), 32'd0);
      if (n >= 3) begin
        check("d3_data", 32'(out_data), 32'(n - 2));
        check("d3_valid", 32'(out_valid), 32'd1);
      end
    end

    // Zero delay is a combinational pass-through
    step(1'b0, 1'b1, 0, 16'hABCD, 1'b1);
    check("d0_data", 32'(out_data), 32'h0000ABCD);
    check("d0_valid", 32'(out_valid), 32'd1);

    // Delay 2, then switch to 5 mid-stream
    for (int j = 0; j < 8; j++) step(1'b0, 1'b1, 2, W'($urandom), 1'b1);
    for (int j = 0; j < 12; j++) begin
      step(1'b0, 1'b1, 5, W'($urandom), 1'b1);
      if (j < 5) check("d5_refill_invalid", 32'(out_valid), 32'd0);
      if (j == 5) check("d5_resume_valid", 32'(out_valid), 32'd1);
    end

    // Delay 4 with en toggling
    for (int j = 0; j < 24; j++) step(1'b0, 1'(j % 2 == 0), 4, W'(16'h0100 + j), 1'b1);

    // Mid-stream reset discards in-flight samples
    step(1'b1, 1'b1, 4, 16'h1234, 1'b1);
    check("mid_rst_data", 32'(out_data), 32'(INIT));
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    for (int j = 0; j < 6; j++) step(1'b0, 1'b1, 4, W'($urandom), 1'b1);

    // Over-range delay behaves as the maximum
    for (int j = 0; j < 12; j++) step(1'b0, 1'b1, 12, W'($urandom), 1'($urandom_range(0, 1)));
`ifdef CONV_REG_ERR_EN
    check("err_set", 32'(delay_err), 32'd1);
`endif
    step(1'b0, 1'b1, 3, W'($urandom), 1'b1);
`ifdef CONV_REG_ERR_EN
    check("err_clear", 32'(delay_err), 32'd0);
`endif

    // Randomized traffic
    dsel = 3;
    for (int j = 0; j < 400; j++) begin
      if ($urandom_range(0, 15) == 0) dsel = int'($urandom_range(0, 11));
      step(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 3) != 0), dsel,
           W'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
